// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters / UART transmit FIFO and uart_tx_arbiter.
// The arbiter connects through the slave modport; the requester/FIFO side uses master.
interface uart_tx_arbiter_if #(
   parameter int DBIT = 8,
   parameter int NREQ = 4
) ();
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      req_last;
   logic [NREQ*DBIT-1:0] req_data;
   logic [NREQ-1:0]      req_ack;
   logic [NREQ-1:0]      grant;
   logic                 wr_uart;
   logic [DBIT-1:0]      w_data;
   logic                 tx_full;
   logic                 busy;

   modport master (
      output req, req_last, req_data, tx_full,
      input  req_ack, grant, wr_uart, w_data, busy
   );

   modport slave (
      input  req, req_last, req_data, tx_full,
      output req_ack, grant, wr_uart, w_data, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ byte streams share one UART transmit FIFO,
// holding a grant for one message or MAX_BURST bytes, whichever ends first.
module uart_tx_arbiter #(
   parameter int DBIT      = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 16
) (
   input  logic             clk,
   input  logic             reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int          CW = $clog2(MAX_BURST) + 1;
   localparam int unsigned N  = NREQ;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state;
   logic [IW-1:0]   gidx;
   logic [IW-1:0]   last_winner;
   logic [IW-1:0]   pick;
   logic            found;
   int unsigned     rr_k;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic [NREQ-1:0] grant_r;
   logic            busy_r;
   logic            sel_req;
   logic            sel_last;
   logic            wr;
   logic [DBIT-1:0] data_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = bus.req_data[i*DBIT +: DBIT];
   end

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      rr_k  = 0;
      for (int unsigned i = 0; i < N; i++) begin
         rr_k = (32'(last_winner) + 1 + i) % N;
         if (!found && bus.req[IW'(rr_k)]) begin
            found = 1'b1;
            pick  = IW'(rr_k);
         end
      end
   end

   always_comb begin
      sel_req    = bus.req[gidx];
      sel_last   = bus.req_last[gidx];
      wr         = (state == GRANT) && sel_req && !bus.tx_full;
      count_next = count + 1'b1;
   end

   always_comb begin
      bus.req_ack = '0;
      if (wr) begin
         bus.req_ack[gidx] = 1'b1;
      end
   end

   assign bus.wr_uart = wr;
   assign bus.w_data  = data_arr[gidx];
   assign bus.grant   = grant_r;
   assign bus.busy    = busy_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         gidx        <= '0;
         last_winner <= IW'(NREQ - 1);
         count       <= '0;
         grant_r     <= '0;
         busy_r      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  state       <= GRANT;
                  gidx        <= pick;
                  last_winner <= pick;
                  count       <= '0;
                  grant_r     <= NREQ'(1) << pick;
                  busy_r      <= 1'b1;
               end
            end
            GRANT: begin
               // A dropped request abandons the message; nothing is written that cycle.
               if (!sel_req) begin
                  state   <= IDLE;
                  grant_r <= '0;
                  busy_r  <= 1'b0;
               end else if (wr) begin
                  count <= count_next;
                  if (sel_last || (count_next == CW'(MAX_BURST))) begin
                     state   <= IDLE;
                     grant_r <= '0;
                     busy_r  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester model, write/grant scoreboards
// checked on the falling edge, plus point checks of latency, stalls, drops and reset.
module tb_uart_tx_arbiter;
   localparam int DBIT      = 8;
   localparam int NREQ      = 4;
   localparam int MAX_BURST = 16;

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_wr  = 0;

   logic [8:0]      src_q [NREQ][$];
   exp_t            exp_q [$];
   int              gexp_q [$];
   logic [NREQ-1:0] acked      = '0;
   logic [NREQ-1:0] abandon    = '0;
   logic [NREQ-1:0] prev_grant = '0;

   uart_tx_arbiter_if #(.DBIT(DBIT), .NREQ(NREQ)) bus ();

   uart_tx_arbiter #(
      .DBIT(DBIT),
      .NREQ(NREQ),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic chk_true(input string tag, input bit cond);
      n_vec++;
      assert (cond) else begin
         n_err++;
         $error("FAIL %s: observed 0 expected 1", tag);
      end
   endtask

   task automatic src_push(input int r, input logic [7:0] d, input logic last);
      src_q[r].push_back({last, d});
   endtask

   task automatic exp_push(input int r, input logic [7:0] d);
      exp_t e;
      e.idx  = 2'(r);
      e.data = d;
      exp_q.push_back(e);
   endtask

   function automatic bit src_empty();
      bit empty = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (src_q[i].size() != 0) empty = 1'b0;
      end
      return empty;
   endfunction

   // Requester model: retire a byte after the edge that accepted it, present the next.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acked[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
         if (abandon[i]) src_q[i].delete();
         if (src_q[i].size() != 0) begin
            bus.req[i]                    = 1'b1;
            bus.req_last[i]               = src_q[i][0][8];
            bus.req_data[i*DBIT +: DBIT]  = src_q[i][0][7:0];
         end else begin
            bus.req[i]                    = 1'b0;
            bus.req_last[i]               = 1'b0;
            bus.req_data[i*DBIT +: DBIT]  = '0;
         end
      end
      acked = '0;
   end

   always @(negedge clk) begin
      exp_t e;
      int   g;
      acked = bus.req_ack;
      if (bus.wr_uart) begin
         n_wr++;
         chk("no_write_when_full", 32'(bus.tx_full), 32'd0);
         chk_true("write_expected", exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("w_data", 32'(bus.w_data), 32'(e.data));
            chk("ack_on_write", 32'(bus.req_ack), 32'(1) << e.idx);
         end
      end else begin
         chk("ack_without_write", 32'(bus.req_ack), 32'd0);
      end
      if (bus.grant != '0) begin
         chk("grant_onehot", 32'($countones(bus.grant)), 32'd1);
         if (prev_grant == '0) begin
            chk_true("grant_expected", gexp_q.size() != 0);
            if (gexp_q.size() != 0) begin
               g = gexp_q.pop_front();
               chk("grant_order", 32'(bus.grant), 32'(1) << g);
            end
         end else begin
            chk("grant_no_direct_switch", 32'(bus.grant), 32'(prev_grant));
         end
      end
      prev_grant = bus.grant;
   end

   task automatic wait_idle(input string tag, input int budget);
      bit done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clk); #3;
         done = (exp_q.size() == 0) && (gexp_q.size() == 0) && (bus.grant == '0) && src_empty();
      end
      chk_true(tag, done);
   endtask

   task automatic wait_grant(input string tag, input int g, input int budget);
      bit done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clk); #3;
         done = (bus.grant == (4'b0001 << g));
      end
      chk_true(tag, done);
   endtask

   task automatic wait_writes(input string tag, input int target, input int budget);
      bit done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk); #1;
         done = (n_wr >= target);
      end
      chk_true(tag, done);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      #1;
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_ack", 32'(bus.req_ack), 32'd0);
      chk("rst_wr", 32'(bus.wr_uart), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      int start;
      reset        = 1'b1;
      bus.req      = '0;
      bus.req_last = '0;
      bus.req_data = '0;
      bus.tx_full  = 1'b0;
      do_reset();

      // Three-byte message from requester 0: latency and back-to-back writes
      @(negedge clk);
      src_push(0, 8'h41, 1'b0); src_push(0, 8'h42, 1'b0); src_push(0, 8'h43, 1'b1);
      exp_push(0, 8'h41); exp_push(0, 8'h42); exp_push(0, 8'h43);
      gexp_q.push_back(0);
      @(posedge clk); #3;
      chk("sel_cycle_grant", 32'(bus.grant), 32'd0);
      chk("sel_cycle_wr", 32'(bus.wr_uart), 32'd0);
      @(posedge clk); #3;
      chk("first_grant", 32'(bus.grant), 32'h1);
      chk("first_busy", 32'(bus.busy), 32'd1);
      chk("first_wr", 32'(bus.wr_uart), 32'd1);
      chk("first_data", 32'(bus.w_data), 32'h41);
      repeat (3) @(posedge clk);
      #3;
      chk("msg_end_grant", 32'(bus.grant), 32'd0);
      chk("msg_end_busy", 32'(bus.busy), 32'd0);
      wait_idle("idle_after_msg0", 50);

      // All four request one-byte messages: round-robin 0,1,2,3,0
      do_reset();
      @(negedge clk);
      src_push(0, 8'hA0, 1'b1); src_push(0, 8'hA1, 1'b1);
      src_push(1, 8'hB1, 1'b1); src_push(2, 8'hC2, 1'b1); src_push(3, 8'hD3, 1'b1);
      exp_push(0, 8'hA0); exp_push(1, 8'hB1); exp_push(2, 8'hC2);
      exp_push(3, 8'hD3); exp_push(0, 8'hA1);
      gexp_q.push_back(0); gexp_q.push_back(1); gexp_q.push_back(2);
      gexp_q.push_back(3); gexp_q.push_back(0);
      wait_idle("idle_after_rr", 100);

      // Requester 2 stalled by tx_full for five cycles mid-message
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         src_push(2, 8'(8'h60 + k), k == 3);
         exp_push(2, 8'(8'h60 + k));
      end
      gexp_q.push_back(2);
      wait_grant("grant_to_2", 2, 20);
      @(posedge clk); #1 bus.tx_full = 1'b1;
      #2;
      chk("stall_wr", 32'(bus.wr_uart), 32'd0);
      chk("stall_ack", 32'(bus.req_ack), 32'd0);
      chk("stall_grant", 32'(bus.grant), 32'h4);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #3;
         chk("stall_wr", 32'(bus.wr_uart), 32'd0);
         chk("stall_grant", 32'(bus.grant), 32'h4);
      end
      @(posedge clk); #1 bus.tx_full = 1'b0;
      wait_idle("idle_after_stall", 50);

      // Burst cap: 20 bytes from 1 with 3 waiting -> 16 from 1, 3's message, 4 from 1
      do_reset();
      @(negedge clk);
      for (int k = 0; k < 20; k++) src_push(1, 8'(8'h80 + k), 1'b0);
      src_push(3, 8'hD0, 1'b0); src_push(3, 8'hD1, 1'b1);
      for (int k = 0; k < 16; k++) exp_push(1, 8'(8'h80 + k));
      exp_push(3, 8'hD0); exp_push(3, 8'hD1);
      for (int k = 16; k < 20; k++) exp_push(1, 8'(8'h80 + k));
      gexp_q.push_back(1); gexp_q.push_back(3); gexp_q.push_back(1);
      wait_idle("idle_after_burst", 200);

      // Requester 0 abandons a five-byte message after two bytes
      start = n_wr;
      @(negedge clk);
      for (int k = 0; k < 5; k++) src_push(0, 8'(8'h30 + k), k == 4);
      exp_push(0, 8'h30); exp_push(0, 8'h31);
      gexp_q.push_back(0);
      wait_writes("two_bytes_sent", start + 2, 20);
      abandon[0] = 1'b1;
      @(posedge clk); #3;
      chk("drop_no_write", 32'(bus.wr_uart), 32'd0);
      chk("drop_still_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #3;
      chk("drop_busy", 32'(bus.busy), 32'd0);
      chk("drop_grant", 32'(bus.grant), 32'd0);
      abandon[0] = 1'b0;
      wait_idle("idle_after_drop", 20);
      chk("drop_write_count", 32'(n_wr), 32'(start + 2));

      // Reset during the second byte of requester 2, then 0 and 1 request
      start = n_wr;
      @(negedge clk);
      src_push(2, 8'hF0, 1'b0); src_push(2, 8'hF1, 1'b0); src_push(2, 8'hF2, 1'b1);
      exp_push(2, 8'hF0);
      gexp_q.push_back(2);
      wait_writes("first_byte_sent", start + 1, 20);
      @(posedge clk); #3;
      chk("second_byte_wr", 32'(bus.wr_uart), 32'd1);
      reset      = 1'b1;
      abandon[2] = 1'b1;
      #1;
      chk("midrst_grant", 32'(bus.grant), 32'd0);
      chk("midrst_ack", 32'(bus.req_ack), 32'd0);
      chk("midrst_wr", 32'(bus.wr_uart), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      src_push(0, 8'hE0, 1'b1); src_push(1, 8'hE1, 1'b1);
      exp_push(0, 8'hE0); exp_push(1, 8'hE1);
      gexp_q.push_back(0); gexp_q.push_back(1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1 abandon = '0;
      @(posedge clk); #3;
      chk("post_rst_grant", 32'(bus.grant), 32'h1);
      wait_idle("idle_after_reset", 50);
      chk("post_rst_writes", 32'(n_wr), 32'(start + 3));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DBIT, default 8, byte width matching the UART data width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum number of bytes per grant.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port req, input, NREQ, per-requester request; held high while that requester has a byte presented.
REQ-007 SHALL have port req_last, input, NREQ, marks the presented byte as the last byte of a message.
REQ-008 SHALL have port req_data, input, NREQ*DBIT, byte for requester i on bits [i*DBIT +: DBIT].
REQ-009 SHALL have port req_ack, output, NREQ, one-cycle pulse when the presented byte is accepted.
REQ-010 SHALL have port grant, output, NREQ, one-hot registered grant; all zero when idle.
REQ-011 SHALL have port wr_uart, output, 1, write strobe to the UART transmit FIFO.
REQ-012 SHALL have port w_data, output, DBIT, byte to the UART transmit FIFO.
REQ-013 SHALL have port tx_full, input, 1, UART transmit FIFO full.
REQ-014 SHALL have port busy, output, 1, high while in GRANT.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-016 In IDLE, with any req bit high, SHALL select the winner round-robin, searching from (last_winner+1) mod NREQ upward with wrap-around.
REQ-017 SHALL register the one-hot grant and enter GRANT on the edge after selection; last_winner is updated to the selected index at the same edge.
REQ-018 In GRANT with granted index g, SHALL drive wr_uart = req[g] & ~tx_full combinationally, with w_data = req_data slice g and req_ack[g] = wr_uart.
REQ-019 SHALL hold req_ack bits other than g, and all req_ack bits in IDLE, at zero; w_data is don't-care when wr_uart is low.
REQ-020 SHALL never assert wr_uart while tx_full is high; the byte stays presented with no ack, and the grant is held.
REQ-021 SHALL count accepted bytes per grant with a counter of $clog2(MAX_BURST)+1 bits, cleared on entry to GRANT.
REQ-022 SHALL return to IDLE, clearing grant, on the edge of an accepted byte when req_last[g] is high or the count reaches MAX_BURST.
REQ-023 SHALL return to IDLE on the edge where req[g] is sampled low in GRANT (abandoned message), with no write that cycle.
REQ-024 After release, the requester SHALL be selected no earlier than the cycle after the return to IDLE (one idle cycle minimum between grants).
REQ-025 Latency: req rising in IDLE with tx_full low SHALL give the first wr_uart two cycles later (selection cycle, then the first GRANT cycle).
REQ-026 Simultaneous requests SHALL be resolved solely by round-robin order; req_last with tx_full high SHALL have no effect until the byte is accepted.
REQ-027 MAX_BURST termination with more bytes pending SHALL re-arbitrate; the same requester wins again only if no other req is high.

Reset
REQ-028 On reset assertion, SHALL go to IDLE immediately (asynchronously) with grant=0, req_ack=0, wr_uart=0, busy=0, count=0, and last_winner=NREQ-1 so that req[0] has first priority.
REQ-029 Reset mid-grant SHALL abort the message with no further write; a partially sent message is not resumed.

Verification
REQ-030 req=4'b0001, data 0x41,0x42,0x43, last on 0x43, tx_full=0 -> grant=0001 one cycle later; three consecutive wr_uart with w_data 41,42,43; then IDLE.
REQ-031 req=4'b1111, every message one byte -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-032 Grant to requester 2, tx_full high for 5 cycles mid-message -> no wr_uart or req_ack during those cycles; grant held; sending resumes with no byte lost or duplicated.
REQ-033 Requester 1 streams 20 bytes without last, requester 3 also requesting, MAX_BURST=16 -> 16 bytes from 1, then a grant to 3, then the remaining 4 bytes from 1.
REQ-034 req[0] dropped after 2 of 5 bytes -> IDLE on the next edge; busy=0; no extra write.
REQ-035 Reset asserted during the second byte of a grant -> all outputs zero within the same cycle; after release with req=4'b0011 -> grant=0001 first.
